// File: rtl/ncl3_sync_sink.sv
`default_nettype none
// ============================================================================
// Module   : ncl3_sync_sink
// Purpose  : Three-rail NCL ring exit. Synchronizes wavefronts into clk, acks
//            upstream, and buffers decoded symbols in a fall-through FIFO.
// Revision : 1.0
// ============================================================================
module ncl3_sync_sink #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     init_n,
    input  logic [2:0]               rail_in,
    output logic                     rail_comp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_sym,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_multi,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_NULL      = 1'b0,
        S_WAIT_NULL = 1'b1
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [2:0]       r_sync [SYNC_STAGES];
    logic [2:0]       r_prev;
    logic [2:0]       w_rail_s;
    logic             w_stable;
    logic             w_one;
    logic             w_multi;
    logic [1:0]       w_sym;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_err;
    logic [1:0]       r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_level;
    logic             r_err_multi;
    logic [CNT_W-1:0] r_err_cnt;

    // Reset asserts asynchronously but releases only after two clk edges.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
            r_prev <= 3'b000;
        end else begin
            r_sync[0] <= rail_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_rail_s;
        end
    end

    // Two identical consecutive samples are required, which masks rail skew.
    assign w_rail_s  = r_sync[SYNC_STAGES-1];
    assign w_stable  = (w_rail_s == r_prev);
    assign w_one     = (w_rail_s == 3'b001) || (w_rail_s == 3'b010) || (w_rail_s == 3'b100);
    assign w_multi   = (w_rail_s != 3'b000) && !w_one;
    assign w_sym     = w_rail_s[2] ? 2'd2 : (w_rail_s[1] ? 2'd1 : 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push_ok = (r_level != c_full) || w_pop;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_NULL;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_NULL: begin
                if (w_stable && w_one && w_push_ok) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_WAIT_NULL;
                end else if (w_stable && w_multi) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_WAIT_NULL;
                end
            end
            S_WAIT_NULL: begin
                if (w_stable && (w_rail_s == 3'b000)) w_state_nxt = S_NULL;
            end
            default: w_state_nxt = S_NULL;
        endcase
    end

    assign rail_comp = (r_state == S_WAIT_NULL);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_sym;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_multi <= 1'b0;
            r_err_cnt   <= '0;
        end else if (w_err) begin
            r_err_multi <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_sym    = out_valid ? r_mem[r_rptr] : 2'd0;
    assign fifo_level = r_level;
    assign err_multi  = r_err_multi;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ncl3_sync_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncl3_sync_sink
// Purpose  : Directed bench for ncl3_sync_sink with a symbol scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ncl3_sync_sink;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             init_n;
    logic [2:0]       rail_in;
    logic             rail_comp;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_sym;
    logic [2:0]       fifo_level;
    logic             err_multi;
    logic [CNT_W-1:0] err_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];

    ncl3_sync_sink #(.DEPTH(DEPTH), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .init_n(init_n), .rail_in(rail_in), .rail_comp(rail_comp),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .fifo_level(fifo_level), .err_multi(err_multi), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (init_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got sym %0d expected none", out_sym);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (out_sym !== e) begin
                    n_bad++;
                    $display("FAIL pop_sym: got %0d expected %0d at %0t", out_sym, e, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_comp(input logic val, input string name);
        int k;
        k = 0;
        while (rail_comp !== val && k < 16) begin
            tick(1);
            k++;
        end
        check(name, int'(rail_comp), int'(val));
    endtask

    task automatic hs(input logic [2:0] code, input logic push, input logic [1:0] sym);
        rail_in = code;
        if (push) exp_q.push_back(sym);
        wait_comp(1'b1, "comp_rise");
        rail_in = 3'b000;
        wait_comp(1'b0, "comp_fall");
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        tick(1);
        while (out_valid && k < 20) begin
            tick(1);
            k++;
        end
        out_ready = 1'b0;
        check("drain_level", int'(fifo_level), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        init_n = 1'b0; rail_in = 3'b000; out_ready = 1'b0;
        tick(3);
        check("rst_comp", int'(rail_comp), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_sym", int'(out_sym), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_err_multi", int'(err_multi), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        init_n = 1'b1;
        tick(4);

        // Exact latency: rail_comp rises on edge 4, falls 4 edges after NULL.
        rail_in = 3'b010; exp_q.push_back(2'd1);
        tick(3);
        check("lat_comp_e3", int'(rail_comp), 0);
        tick(1);
        check("lat_comp_e4", int'(rail_comp), 1);
        check("lat_valid", int'(out_valid), 1);
        check("lat_sym", int'(out_sym), 1);
        check("lat_level", int'(fifo_level), 1);
        rail_in = 3'b000;
        tick(3);
        check("lat_fall_e3", int'(rail_comp), 1);
        tick(1);
        check("lat_fall_e4", int'(rail_comp), 0);
        drain();

        // Backpressure: fifth wavefront waits until a pop frees a slot.
        hs(3'b001, 1'b1, 2'd0);
        hs(3'b010, 1'b1, 2'd1);
        hs(3'b100, 1'b1, 2'd2);
        hs(3'b001, 1'b1, 2'd0);
        check("bp_full_level", int'(fifo_level), 4);
        rail_in = 3'b010; exp_q.push_back(2'd1);
        tick(8);
        check("bp_comp_held", int'(rail_comp), 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_level_after", int'(fifo_level), 4);
        check("bp_comp_after", int'(rail_comp), 1);
        rail_in = 3'b000;
        wait_comp(1'b0, "bp_comp_fall");
        drain();

        // Skew: rail0 glitches for one clock while rail2 settles.
        out_ready = 1'b1;
        rail_in = 3'b100; exp_q.push_back(2'd2);
        tick(1);
        rail_in = 3'b101;
        tick(1);
        rail_in = 3'b100;
        wait_comp(1'b1, "skew_rise");
        rail_in = 3'b000;
        wait_comp(1'b0, "skew_fall");
        tick(2);
        out_ready = 1'b0;
        check("skew_err_multi", int'(err_multi), 0);
        check("skew_err_cnt", int'(err_cnt), 0);
        check("skew_queue", exp_q.size(), 0);

        // Full FIFO with pop on the same edge as the push.
        hs(3'b100, 1'b1, 2'd2);
        hs(3'b010, 1'b1, 2'd1);
        hs(3'b001, 1'b1, 2'd0);
        hs(3'b100, 1'b1, 2'd2);
        rail_in = 3'b001; exp_q.push_back(2'd0);
        tick(3);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("sim_comp", int'(rail_comp), 1);
        check("sim_level", int'(fifo_level), 4);
        rail_in = 3'b000;
        wait_comp(1'b0, "sim_fall");
        drain();

        // Reset mid-wavefront with three entries held.
        hs(3'b001, 1'b1, 2'd0);
        hs(3'b010, 1'b1, 2'd1);
        rail_in = 3'b100; exp_q.push_back(2'd2);
        wait_comp(1'b1, "mid_rise");
        check("mid_level_pre", int'(fifo_level), 3);
        #2 init_n = 1'b0;
        #1;
        check("mid_comp", int'(rail_comp), 0);
        check("mid_valid", int'(out_valid), 0);
        check("mid_level", int'(fifo_level), 0);
        exp_q.delete();
        rail_in = 3'b001; exp_q.push_back(2'd0);
        tick(2);
        init_n = 1'b1;
        wait_comp(1'b1, "post_rst_rise");
        check("post_rst_level", int'(fifo_level), 1);
        check("post_rst_sym", int'(out_sym), 0);
        rail_in = 3'b000;
        wait_comp(1'b0, "post_rst_fall");
        drain();

        // Illegal codes: counted, discarded, counter saturates.
        for (int i = 0; i < 300; i++) begin
            hs((i % 3 == 0) ? 3'b110 : ((i % 3 == 1) ? 3'b011 : 3'b111), 1'b0, 2'd0);
            if (i == 0) begin
                check("err_first_multi", int'(err_multi), 1);
                check("err_first_cnt", int'(err_cnt), 1);
                check("err_first_level", int'(fifo_level), 0);
            end
            if (i == 254) check("err_cnt_255", int'(err_cnt), 255);
        end
        check("err_cnt_sat", int'(err_cnt), 255);
        check("err_level", int'(fifo_level), 0);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ncl3_sync_sink.md
Name: ncl3_sync_sink

Overview:
- Ring-exit stage: consumes the three-rail NCL wavefronts produced by the last pipeline component of a three-rail ring.
- Drives that component's completion input, using the same NCL handshake as a pipeline stage.
- Each DATA wavefront is converted to a 2-bit binary symbol and buffered in a small FIFO.
- The FIFO is presented to the clocked system on a valid/ready interface. Illegal multi-rail codes are counted and flagged.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
SYNC_STAGES, 2, synchronizer flops per rail (>=2)
CNT_W, 8, width of illegal-code counter

Ports:
clk  in  1  system clock
init_n  in  1  asynchronous active-low reset
rail_in  in  3  three-rail NCL data from upstream stage; asynchronous to clk
rail_comp  out  1  completion to upstream stage: 1 = DATA accepted, request NULL; 0 = NULL seen, request DATA
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_sym  out  2  head symbol: rail0->0, rail1->1, rail2->2
fifo_level  out  $clog2(DEPTH)+1  entries held
err_multi  out  1  sticky: illegal code (>1 rail high) seen since reset
err_cnt  out  CNT_W  count of illegal codes, saturating at all-ones

Behaviour:
- Reset (init_n=0, async): all sync flops, rail_prev, FSM, FIFO pointers, counter = 0; rail_comp=0, out_valid=0, out_sym=0, fifo_level=0, err_multi=0, err_cnt=0. Deassertion is synchronized internally (2-flop) before the FSM leaves reset.
- Synchronizer: each rail passes through SYNC_STAGES flops, giving rail_s. rail_prev registers rail_s each cycle. stable = (rail_s == rail_prev); this absorbs inter-rail skew.
- FSM state NULL (rail_comp=0), waiting for DATA:
  - stable, exactly one bit set, push allowed: write symbol, rail_comp<=1, go WAIT_NULL.
  - stable, exactly one bit set, push not allowed: hold in NULL, rail_comp stays 0. This is backpressure.
  - stable, >=2 bits set: no push; err_multi<=1; err_cnt increments (saturating); rail_comp<=1; go WAIT_NULL. The wavefront is discarded.
  - rail_s==000 or not stable: stay.
- FSM state WAIT_NULL (rail_comp=1):
  - stable and rail_s==000: rail_comp<=0, go NULL.
  - Any other rail_s value: stay.
- push allowed = !full || (out_valid && out_ready). A simultaneous pop frees the slot in the same cycle.
- Latency: count as edge 1 the first rising edge that samples a new rail_in value. rail_comp changes at edge SYNC_STAGES+2 (edge 4 with defaults).
- FIFO: first-word fall-through. A push into an empty FIFO raises out_valid on the same edge as rail_comp rises.
- Pop occurs on an edge where out_valid && out_ready.
- fifo_level:
  - Simultaneous push+pop leaves it unchanged.
  - Pointers wrap modulo DEPTH.
  - Full when fifo_level==DEPTH. Empty gives out_valid=0.
- out_sym is stable while out_valid=1 and out_ready=0.
- Reset mid-wavefront: rail_comp drops to 0 asynchronously and FIFO contents are lost. After reset the FSM starts in NULL. If rail_in still holds DATA, that DATA is accepted as a new wavefront (documented behaviour).

Test Plan:
- Reset, then rail_in=010 held -> rail_comp rises at edge 4; out_valid=1, out_sym=1, fifo_level=1. Then rail_in=000 -> rail_comp falls 4 edges later.
- out_ready=0; five handshakes with symbols 0,1,2,0,1 (DEPTH=4) -> fifo_level=4. The fifth wavefront leaves rail_comp=0 held. Pulse out_ready one cycle -> pops 0, fifth accepted; fifo_level=4; later pops read 1,2,0,1 in order.
- rail_in=110 stable -> no push; err_multi=1, err_cnt=1; rail_comp=1 until 000. Repeat 300 times with CNT_W=8 -> err_cnt=255.
- Skewed arrival: rail2 rises, and rail0 glitches high for 1 clock then low -> exactly one push of symbol 2 and no error. Data is accepted only after two identical samples.
- Full FIFO with out_ready=1 while a new wavefront becomes stable -> push and pop occur on the same edge; fifo_level stays 4 and the symbol is accepted.
- Assert init_n=0 while rail_comp=1 with 3 entries -> rail_comp=0, out_valid=0, fifo_level=0 immediately. Release with rail_in=001 -> new accept of symbol 0 at edge 4 after the reset synchronizer releases.
